// File: rtl/gcd_sequencer_if.sv
// Handshake and datapath-control bundle between gcd_sequencer (master) and
// the surrounding system / datapath_section1 (slave).
interface gcd_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             a_eq_b;
    logic             a_lt_b;
    logic             a_is_zero;
    logic             b_is_zero;
    logic             CTRL1;
    logic             CTRL2;
    logic             CTRL6;
    logic             CTRL7;
    logic             busy;
    logic             gcd_done;
    logic             gcd_err;
    logic [CNT_W-1:0] iter_count;

    modport master (
        input  start, a_eq_b, a_lt_b, a_is_zero, b_is_zero,
        output CTRL1, CTRL2, CTRL6, CTRL7, busy, gcd_done, gcd_err, iter_count
    );

    modport slave (
        output start, a_eq_b, a_lt_b, a_is_zero, b_is_zero,
        input  CTRL1, CTRL2, CTRL6, CTRL7, busy, gcd_done, gcd_err, iter_count
    );
endinterface

// File: rtl/gcd_sequencer.sv
// Control FSM sequencing a subtractive-GCD datapath with a start/done handshake.
// Optional iteration limit enabled by defining GCD_ITER_LIMIT_EN.
module gcd_sequencer #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MAX_ITER = 65535
) (
    input  logic             CLK,
    input  logic             RST_N,
    gcd_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        SUB_A,
        SUB_B,
        DONE,
        ERR
    } state_t;

`ifdef GCD_ITER_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] ITER_LIMIT = CNT_W'(MAX_ITER);

    state_t state;
    state_t nxt;
    logic   limit_hit;

    assign limit_hit = LIMIT_EN && (bus.iter_count == ITER_LIMIT);

    // Zero check outranks equality so A=B=0 reports an error, not a result.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:        if (bus.start) nxt = LOAD;
            LOAD:        nxt = CHECK;
            CHECK: begin
                if (bus.a_is_zero || bus.b_is_zero) nxt = ERR;
                else if (bus.a_eq_b)                nxt = DONE;
                else if (limit_hit)                 nxt = ERR;
                else if (bus.a_lt_b)                nxt = SUB_B;
                else                                nxt = SUB_A;
            end
            SUB_A, SUB_B: nxt = CHECK;
            DONE, ERR:   if (!bus.start) nxt = IDLE;
            default:     nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they track the state
    // register exactly with no input-to-output combinational path.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state          <= IDLE;
            bus.CTRL1      <= 1'b0;
            bus.CTRL2      <= 1'b0;
            bus.CTRL6      <= 1'b0;
            bus.CTRL7      <= 1'b0;
            bus.busy       <= 1'b0;
            bus.gcd_done   <= 1'b0;
            bus.gcd_err    <= 1'b0;
            bus.iter_count <= '0;
        end else begin
            state        <= nxt;
            bus.CTRL1    <= (nxt == LOAD);
            bus.CTRL2    <= (nxt == LOAD);
            bus.CTRL6    <= (nxt == SUB_B);
            bus.CTRL7    <= (nxt == SUB_A) || (nxt == SUB_B);
            bus.busy     <= (nxt != IDLE);
            bus.gcd_done <= (nxt == DONE);
            bus.gcd_err  <= (nxt == ERR);
            if (nxt == LOAD) begin
                bus.iter_count <= '0;
            end else if (((nxt == SUB_A) || (nxt == SUB_B)) && (bus.iter_count != '1)) begin
                bus.iter_count <= bus.iter_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gcd_sequencer.sv
// Directed self-checking bench for gcd_sequencer with a behavioural datapath model.
module tb_gcd_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic        sel = 1'b0;
    logic [15:0] ain = '0;
    logic [15:0] bin = '0;
    logic [15:0] a0, b0, a1, b1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    gcd_sequencer_if #(.CNT_W(16)) if0 ();
    gcd_sequencer_if #(.CNT_W(4))  if1 ();

    gcd_sequencer #(.CNT_W(16), .MAX_ITER(65535)) dut0 (.CLK(CLK), .RST_N(RST_N), .bus(if0));
    gcd_sequencer #(.CNT_W(4),  .MAX_ITER(4))     dut1 (.CLK(CLK), .RST_N(RST_N), .bus(if1));

    // datapath_section1 models, one per sequencer
    always_ff @(posedge CLK) begin
        if (if0.CTRL1) a0 <= ain;
        if (if0.CTRL2) b0 <= bin;
        if (if0.CTRL7) begin
            if (if0.CTRL6) b0 <= b0 - a0;
            else           a0 <= a0 - b0;
        end
    end
    always_ff @(posedge CLK) begin
        if (if1.CTRL1) a1 <= ain;
        if (if1.CTRL2) b1 <= bin;
        if (if1.CTRL7) begin
            if (if1.CTRL6) b1 <= b1 - a1;
            else           a1 <= a1 - b1;
        end
    end

    assign if0.start     = start & ~sel;
    assign if0.a_eq_b    = (a0 == b0);
    assign if0.a_lt_b    = (a0 < b0);
    assign if0.a_is_zero = (a0 == 16'd0);
    assign if0.b_is_zero = (b0 == 16'd0);
    assign if1.start     = start & sel;
    assign if1.a_eq_b    = (a1 == b1);
    assign if1.a_lt_b    = (a1 < b1);
    assign if1.a_is_zero = (a1 == 16'd0);
    assign if1.b_is_zero = (b1 == 16'd0);

    logic        o_c1, o_c2, o_c6, o_c7, o_busy, o_done, o_err;
    logic [15:0] o_iter;
    logic [15:0] o_a, o_b;
    assign o_c1   = sel ? if1.CTRL1    : if0.CTRL1;
    assign o_c2   = sel ? if1.CTRL2    : if0.CTRL2;
    assign o_c6   = sel ? if1.CTRL6    : if0.CTRL6;
    assign o_c7   = sel ? if1.CTRL7    : if0.CTRL7;
    assign o_busy = sel ? if1.busy     : if0.busy;
    assign o_done = sel ? if1.gcd_done : if0.gcd_done;
    assign o_err  = sel ? if1.gcd_err  : if0.gcd_err;
    assign o_iter = sel ? 16'(if1.iter_count) : if0.iter_count;
    assign o_a    = sel ? a1 : a0;
    assign o_b    = sel ? b1 : b0;

    // Edges are counted from the edge just before start is raised, so start is
    // first sampled at edge 1 and a result with N subtractions lands at 3+2N.
    task automatic run(input logic [15:0] a, input logic [15:0] b, input int budget,
                       input int drop_at, output int edges, output int pulses,
                       output bit c6_seen, output bit viol);
        int cnt;
        @(posedge CLK); #1;
        ain = a; bin = b; start = 1'b1;
        edges = 0; pulses = 0; c6_seen = 1'b0; viol = 1'b0;
        while (edges < budget) begin
            @(posedge CLK); #1;
            edges++;
            if (edges == drop_at)     start = 1'b0;
            if (edges == drop_at + 1) start = 1'b1;
            if (o_c7) pulses++;
            if (o_c6) c6_seen = 1'b1;
            cnt = int'(o_c1 | o_c2) + int'(o_c7) + int'(o_done) + int'(o_err);
            if (cnt > 1 || (o_c6 && !o_c7) || (o_c1 != o_c2)) viol = 1'b1;
            if (o_done || o_err) break;
        end
    endtask

    task automatic release_start();
        start = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({o_c1, o_c2, o_c6, o_c7, o_busy, o_done, o_err} !== 7'd0) begin
            n_err++;
            $display("FAIL reset_outputs got=%b want=0000000", {o_c1, o_c2, o_c6, o_c7, o_busy, o_done, o_err});
        end
        n_cmp++;
        if (o_iter !== 16'd0) begin
            n_err++;
            $display("FAIL reset_iter got=%0d want=0", o_iter);
        end
    endtask

    task automatic test_long_run();
        int e, p; bit c6, v;
        sel = 1'b0;
        run(16'd4620, 16'd10, 2000, -1, e, p, c6, v);
        n_cmp++; if (!(o_done === 1'b1 && e == 925)) begin n_err++; $display("FAIL long_done_edge got=%0d done=%b want=925", e, o_done); end
        n_cmp++; if (o_iter !== 16'd461) begin n_err++; $display("FAIL long_iter got=%0d want=461", o_iter); end
        n_cmp++; if (p != 461) begin n_err++; $display("FAIL long_pulses got=%0d want=461", p); end
        n_cmp++; if (c6 !== 1'b0) begin n_err++; $display("FAIL long_ctrl6 got=%b want=0", c6); end
        n_cmp++; if (o_a !== 16'd10 || o_b !== 16'd10) begin n_err++; $display("FAIL long_result got=%0d/%0d want=10/10", o_a, o_b); end
        n_cmp++; if (v) begin n_err++; $display("FAIL long_exclusive got=1 want=0"); end
        release_start();
    endtask

    task automatic test_two_way();
        int e, p; bit c6, v;
        sel = 1'b0;
        run(16'd12, 16'd18, 100, -1, e, p, c6, v);
        n_cmp++; if (!(o_done === 1'b1 && e == 7)) begin n_err++; $display("FAIL mix_done_edge got=%0d done=%b want=7", e, o_done); end
        n_cmp++; if (o_iter !== 16'd2 || o_a !== 16'd6 || o_b !== 16'd6) begin n_err++; $display("FAIL mix_result got=iter%0d %0d/%0d want=iter2 6/6", o_iter, o_a, o_b); end
        n_cmp++; if (c6 !== 1'b1 || v) begin n_err++; $display("FAIL mix_ctrl got=c6:%b viol:%b want=c6:1 viol:0", c6, v); end
        repeat (3) @(posedge CLK); #1;
        n_cmp++; if (o_done !== 1'b1 || o_busy !== 1'b1) begin n_err++; $display("FAIL mix_hold got=done%b busy%b want=11", o_done, o_busy); end
        release_start();
        n_cmp++; if (o_busy !== 1'b0 || o_done !== 1'b0 || o_iter !== 16'd2) begin n_err++; $display("FAIL mix_idle got=busy%b done%b iter%0d want=0 0 2", o_busy, o_done, o_iter); end
    endtask

    task automatic test_zero_operand();
        int e, p; bit c6, v;
        sel = 1'b0;
        run(16'd0, 16'd10, 100, -1, e, p, c6, v);
        n_cmp++; if (!(o_err === 1'b1 && o_done === 1'b0 && e == 3)) begin n_err++; $display("FAIL zero_err got=edge%0d err%b done%b want=edge3 err1 done0", e, o_err, o_done); end
        n_cmp++; if (p != 0 || o_iter !== 16'd0) begin n_err++; $display("FAIL zero_nosub got=pulses%0d iter%0d want=0 0", p, o_iter); end
        release_start();
        run(16'd0, 16'd0, 100, -1, e, p, c6, v);
        n_cmp++; if (!(o_err === 1'b1 && o_done === 1'b0)) begin n_err++; $display("FAIL both_zero got=err%b done%b want=err1 done0", o_err, o_done); end
        release_start();
    endtask

`ifdef GCD_ITER_LIMIT_EN
    task automatic test_iter_limit();
        int e, p; bit c6, v;
        sel = 1'b1;
        run(16'd4620, 16'd10, 200, -1, e, p, c6, v);
        n_cmp++; if (!(o_err === 1'b1 && e == 11)) begin n_err++; $display("FAIL limit_err got=edge%0d err%b want=edge11 err1", e, o_err); end
        n_cmp++; if (p != 4 || o_iter !== 16'd4) begin n_err++; $display("FAIL limit_count got=pulses%0d iter%0d want=4 4", p, o_iter); end
        release_start();
        sel = 1'b0;
    endtask
`else
    task automatic test_saturation();
        int e, p; bit c6, v;
        sel = 1'b1;
        run(16'd40, 16'd1, 500, -1, e, p, c6, v);
        n_cmp++; if (!(o_done === 1'b1 && e == 81)) begin n_err++; $display("FAIL sat_done got=edge%0d done%b want=edge81 done1", e, o_done); end
        n_cmp++; if (o_iter !== 16'd15 || o_a !== 16'd1 || p != 39) begin n_err++; $display("FAIL sat_iter got=iter%0d a%0d pulses%0d want=15 1 39", o_iter, o_a, p); end
        release_start();
        sel = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_run();
        int e, p, n; bit c6, v;
        sel = 1'b0;
        @(posedge CLK); #1;
        ain = 16'd4620; bin = 16'd10; start = 1'b1;
        n = 0;
        while (n < 1000 && !(o_c7 && o_iter == 16'd100)) begin
            @(posedge CLK); #1;
            n++;
        end
        n_cmp++; if (n >= 1000) begin n_err++; $display("FAIL midrun_reach got=timeout want=iter100"); end
        #1 RST_N = 1'b0;
        #1;
        n_cmp++; if ({o_c1, o_c2, o_c6, o_c7, o_busy, o_done, o_err} !== 7'd0 || o_iter !== 16'd0) begin
            n_err++; $display("FAIL midrun_reset got=%b iter%0d want=0000000 iter0", {o_c1, o_c2, o_c6, o_c7, o_busy, o_done, o_err}, o_iter);
        end
        start = 1'b0;
        @(negedge CLK); RST_N = 1'b1;
        run(16'd12, 16'd18, 100, -1, e, p, c6, v);
        n_cmp++; if (!(o_done === 1'b1 && e == 7 && o_iter === 16'd2)) begin n_err++; $display("FAIL midrun_rerun got=edge%0d iter%0d want=edge7 iter2", e, o_iter); end
        release_start();
    endtask

    task automatic test_start_pulse_busy();
        int e, p; bit c6, v;
        sel = 1'b0;
        run(16'd12, 16'd18, 100, 3, e, p, c6, v);
        n_cmp++; if (!(o_done === 1'b1 && e == 7 && o_iter === 16'd2 && p == 2)) begin n_err++; $display("FAIL pulse_busy got=edge%0d iter%0d pulses%0d want=7 2 2", e, o_iter, p); end
        release_start();
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        test_reset();
        @(negedge CLK); RST_N = 1'b1;
        test_long_run();
        test_two_way();
        test_zero_operand();
`ifdef GCD_ITER_LIMIT_EN
        test_iter_limit();
`else
        test_saturation();
`endif
        test_reset_mid_run();
        test_start_pulse_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
